scu_dsp_host_port: RTL and testbench
====================================

Name: scu_dsp_host_port

Overview:
- Host-side access stage sitting directly upstream of the SCU DSP program RAM (256x32) and data RAM (4 banks x 64x32).
- Decodes host register accesses to the DSP program/data port registers.
- Keeps the auto-incrementing program and data RAM address counters.
- Drives the write ports of both RAMs and sequences data-RAM reads across the RAM read latency.
- Issues the program-counter load request to the DSP core.

Parameters:
RD_LAT, 1, cycles from DAT_ADDR valid to DAT_Q valid (1 or 2).
PRG_AW, 8, program RAM address width.
DAT_AW, 8, data RAM address width (bank[7:6], word[5:0]).

Ports:
CLK  in  1  system clock
RST_N  in  1  reset
CE  in  1  host access strobe, held until RDY
WE  in  1  1=write, 0=read
A  in  2  register select: 0=PPAF, 1=PPD, 2=PDA, 3=PDD
DI  in  32  host write data
DO  out  32  host read data
RDY  out  1  one-cycle access-complete pulse
DSP_EX  in  1  DSP executing; blocks PPD/PDD RAM writes
PRG_ADDR  out  PRG_AW  program RAM address
PRG_DATA  out  32  program RAM write data
PRG_WE  out  1  program RAM write enable
DAT_ADDR  out  DAT_AW  data RAM address
DAT_DATA  out  32  data RAM write data
DAT_WE  out  1  data RAM write enable
DAT_Q  in  32  data RAM read data
PC_LOAD  out  1  one-cycle PC load pulse to DSP core
PC_VAL  out  8  PC load value

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-low (CLK, RST_N).
- Reset values:
  - Outputs: all outputs 0; PRG_ADDR=0, DAT_ADDR=0, DO=0, RDY=0, PC_LOAD=0.
  - State: FSM=IDLE.
- FSM states: IDLE, WR, RD_WAIT, RD_DONE. Transitions:
  - IDLE, CE&WE -> WR: perform the register action this cycle; RDY=1 next cycle; back to IDLE.
  - IDLE, CE&!WE&A==3 -> RD_WAIT. DAT_ADDR is already stable, so count RD_LAT cycles, then -> RD_DONE.
  - RD_DONE: latch DAT_Q into DO, RDY=1, DAT_ADDR+=1, -> IDLE.
  - IDLE, CE&!WE&A!=3 -> WR path with no side effects:
    - DO=0 for PPAF/PPD.
    - DO={24'b0,DAT_ADDR} for PDA.
    - RDY next cycle.
  - After RDY the FSM ignores CE for one cycle, so a held CE is not re-accepted. Next access is accepted 2 cycles after RDY.
- Write actions:
  - PPAF: PRG_ADDR<=DI[7:0]. If DI[15]=1: PC_VAL<=DI[7:0], PC_LOAD pulses 1 cycle.
  - PPD:
    - If !DSP_EX: PRG_WE=1 for exactly one cycle with PRG_DATA=DI at the current PRG_ADDR, then PRG_ADDR+=1.
    - If DSP_EX: no write, no increment, RDY still given.
  - PDA: DAT_ADDR<=DI[7:0].
  - PDD: same as PPD but on the data RAM (DAT_WE, DAT_DATA, DAT_ADDR).
- Address arithmetic: both counters increment modulo 2^width. 0xFF->0x00 wraps, and the data counter crosses banks (0x3F->0x40).
- Writes never stall; reads take 2+RD_LAT cycles from CE to RDY.
- DSP_EX rising during a PDD read does not abort the read (reads are always allowed).
- Reset mid-access: immediate return to IDLE, no RDY, counters cleared, any pending WE dropped.
- PRG_WE and DAT_WE are never asserted in the same cycle.

Decomposition:
- Package scu_dsp_pkg holds:
  - register-select constants REG_PPAF=0, REG_PPD=1, REG_PDA=2, REG_PDD=3;
  - the FSM state enum;
  - the PPAF LE bit index (15).
- No sub-module: single module, about 150-200 lines RTL.

Test Plan:
- Reset, then PPAF write DI=0x0000_0010 -> PRG_ADDR=0x10, PC_LOAD stays 0.
- Then three PPD writes 0xA,0xB,0xC -> PRG_WE pulses at addresses 0x10,0x11,0x12; PRG_ADDR ends 0x13.
- PPAF write DI=0x0000_80FF, then PPD writes 0x1 and 0x2 -> PC_LOAD one pulse with PC_VAL=0xFF; writes land at 0xFF and 0x00 (wrap).
- PDA write 0x3F, then PDD write 0x55 -> DAT_WE at 0x3F, DAT_ADDR=0x40 (bank crossing).
- PDA write 0x40 with the RAM model holding 0x1234_5678 at 0x40, RD_LAT=1, then PDD read -> RDY 3 cycles after CE, DO=0x1234_5678, DAT_ADDR=0x41.
- Same read with RD_LAT=2 -> RDY 4 cycles after CE.
- DSP_EX=1, then PPD write 0xDEAD -> RDY given, PRG_WE never 1, PRG_ADDR unchanged.
- PDD read started, then RST_N low in RD_WAIT -> RDY stays 0, DAT_ADDR=0, FSM=IDLE.
- After RST_N high, PDA read -> DO=0.

Source files
------------

// File: rtl/scu_dsp_pkg.sv
// Shared constants and types for the SCU DSP host port: register selects,
// FSM state encoding and PPAF field positions.
package scu_dsp_pkg;

    localparam int unsigned DATA_W      = 32;
    localparam int unsigned PC_W        = 8;
    localparam int unsigned SEL_W       = 2;
    localparam int unsigned LAT_CNT_W   = 2;
    localparam int unsigned PPAF_LE_BIT = 15;

    localparam logic [SEL_W-1:0] REG_PPAF = 2'd0;
    localparam logic [SEL_W-1:0] REG_PPD  = 2'd1;
    localparam logic [SEL_W-1:0] REG_PDA  = 2'd2;
    localparam logic [SEL_W-1:0] REG_PDD  = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR      = 2'd1,
        RD_WAIT = 2'd2,
        RD_DONE = 2'd3
    } hp_state_e;

endpackage

// File: rtl/scu_dsp_host_port.sv
// Host register port for the SCU DSP: decodes PPAF/PPD/PDA/PDD accesses, owns the
// auto-incrementing program/data RAM address counters and sequences data-RAM reads.
module scu_dsp_host_port
    import scu_dsp_pkg::*;
#(
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned PRG_AW = 8,
    parameter int unsigned DAT_AW = 8
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                CE,
    input  logic                WE,
    input  logic [SEL_W-1:0]    A,
    input  logic [DATA_W-1:0]   DI,
    output logic [DATA_W-1:0]   DO,
    output logic                RDY,
    input  logic                DSP_EX,
    output logic [PRG_AW-1:0]   PRG_ADDR,
    output logic [DATA_W-1:0]   PRG_DATA,
    output logic                PRG_WE,
    output logic [DAT_AW-1:0]   DAT_ADDR,
    output logic [DATA_W-1:0]   DAT_DATA,
    output logic                DAT_WE,
    input  logic [DATA_W-1:0]   DAT_Q,
    output logic                PC_LOAD,
    output logic [PC_W-1:0]     PC_VAL
);

    hp_state_e              state_q, state_d;
    logic [LAT_CNT_W-1:0]   cnt_q, cnt_d;
    logic                   rdy_q, rdy_d;
    logic [DATA_W-1:0]      do_q, do_d;
    logic [PRG_AW-1:0]      prg_addr_q, prg_addr_d;
    logic [DATA_W-1:0]      prg_data_q, prg_data_d;
    logic                   prg_we_q, prg_we_d;
    logic [DAT_AW-1:0]      dat_addr_q, dat_addr_d;
    logic [DATA_W-1:0]      dat_data_q, dat_data_d;
    logic                   dat_we_q, dat_we_d;
    logic                   pc_load_q, pc_load_d;
    logic [PC_W-1:0]        pc_val_q, pc_val_d;

    // A held CE is ignored in the cycle RDY is high so it is not re-accepted.
    logic accept_c;
    assign accept_c = CE && !rdy_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rdy_q      <= 1'b0;
            do_q       <= '0;
            prg_addr_q <= '0;
            prg_data_q <= '0;
            prg_we_q   <= 1'b0;
            dat_addr_q <= '0;
            dat_data_q <= '0;
            dat_we_q   <= 1'b0;
            pc_load_q  <= 1'b0;
            pc_val_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rdy_q      <= rdy_d;
            do_q       <= do_d;
            prg_addr_q <= prg_addr_d;
            prg_data_q <= prg_data_d;
            prg_we_q   <= prg_we_d;
            dat_addr_q <= dat_addr_d;
            dat_data_q <= dat_data_d;
            dat_we_q   <= dat_we_d;
            pc_load_q  <= pc_load_d;
            pc_val_q   <= pc_val_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rdy_d      = 1'b0;
        do_d       = do_q;
        prg_addr_d = prg_addr_q;
        prg_data_d = prg_data_q;
        prg_we_d   = 1'b0;
        dat_addr_d = dat_addr_q;
        dat_data_d = dat_data_q;
        dat_we_d   = 1'b0;
        pc_load_d  = 1'b0;
        pc_val_d   = pc_val_q;

        // Post-increment once the RAM has seen the write at the old address.
        if (prg_we_q) begin
            prg_addr_d = prg_addr_q + PRG_AW'(1);
        end
        if (dat_we_q) begin
            dat_addr_d = dat_addr_q + DAT_AW'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (accept_c) begin
                    if (WE) begin
                        state_d = WR;
                        case (A)
                            REG_PPAF: begin
                                prg_addr_d = PRG_AW'(DI[7:0]);
                                if (DI[PPAF_LE_BIT]) begin
                                    pc_val_d  = DI[PC_W-1:0];
                                    pc_load_d = 1'b1;
                                end
                            end
                            REG_PPD: begin
                                if (!DSP_EX) begin
                                    prg_we_d   = 1'b1;
                                    prg_data_d = DI;
                                end
                            end
                            REG_PDA: begin
                                dat_addr_d = DAT_AW'(DI[7:0]);
                            end
                            default: begin
                                if (!DSP_EX) begin
                                    dat_we_d   = 1'b1;
                                    dat_data_d = DI;
                                end
                            end
                        endcase
                    end else if (A == REG_PDD) begin
                        state_d = RD_WAIT;
                        cnt_d   = '0;
                    end else begin
                        state_d = WR;
                        do_d    = (A == REG_PDA) ? DATA_W'(dat_addr_q) : '0;
                    end
                end
            end
            WR: begin
                rdy_d   = 1'b1;
                state_d = IDLE;
            end
            RD_WAIT: begin
                if (cnt_q == LAT_CNT_W'(RD_LAT - 1)) begin
                    state_d = RD_DONE;
                end else begin
                    cnt_d = cnt_q + LAT_CNT_W'(1);
                end
            end
            RD_DONE: begin
                do_d       = DAT_Q;
                rdy_d      = 1'b1;
                dat_addr_d = dat_addr_q + DAT_AW'(1);
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign DO       = do_q;
    assign RDY      = rdy_q;
    assign PRG_ADDR = prg_addr_q;
    assign PRG_DATA = prg_data_q;
    assign PRG_WE   = prg_we_q;
    assign DAT_ADDR = dat_addr_q;
    assign DAT_DATA = dat_data_q;
    assign DAT_WE   = dat_we_q;
    assign PC_LOAD  = pc_load_q;
    assign PC_VAL   = pc_val_q;

endmodule

// File: tb/tb_scu_dsp_host_port.sv
// Bench for scu_dsp_host_port: two instances (RD_LAT=1 and RD_LAT=2) with RAM models,
// a directed vector table, a mid-read reset sequence and randomized accesses vs a model.
module tb_scu_dsp_host_port;

    logic        CLK;
    logic        RST_N;
    logic        ce [2];
    logic        WE;
    logic [1:0]  A;
    logic [31:0] DI;
    logic        DSP_EX;

    logic [31:0] do_w       [2];
    logic        rdy_w      [2];
    logic [7:0]  prg_addr_w [2];
    logic [31:0] prg_data_w [2];
    logic        prg_we_w   [2];
    logic [7:0]  dat_addr_w [2];
    logic [31:0] dat_data_w [2];
    logic        dat_we_w   [2];
    logic [31:0] dat_q_w    [2];
    logic        pc_load_w  [2];
    logic [7:0]  pc_val_w   [2];

    scu_dsp_host_port #(.RD_LAT(1), .PRG_AW(8), .DAT_AW(8)) dut0 (
        .CLK(CLK), .RST_N(RST_N), .CE(ce[0]), .WE(WE), .A(A), .DI(DI), .DO(do_w[0]),
        .RDY(rdy_w[0]), .DSP_EX(DSP_EX), .PRG_ADDR(prg_addr_w[0]), .PRG_DATA(prg_data_w[0]),
        .PRG_WE(prg_we_w[0]), .DAT_ADDR(dat_addr_w[0]), .DAT_DATA(dat_data_w[0]),
        .DAT_WE(dat_we_w[0]), .DAT_Q(dat_q_w[0]), .PC_LOAD(pc_load_w[0]), .PC_VAL(pc_val_w[0])
    );

    scu_dsp_host_port #(.RD_LAT(2), .PRG_AW(8), .DAT_AW(8)) dut1 (
        .CLK(CLK), .RST_N(RST_N), .CE(ce[1]), .WE(WE), .A(A), .DI(DI), .DO(do_w[1]),
        .RDY(rdy_w[1]), .DSP_EX(DSP_EX), .PRG_ADDR(prg_addr_w[1]), .PRG_DATA(prg_data_w[1]),
        .PRG_WE(prg_we_w[1]), .DAT_ADDR(dat_addr_w[1]), .DAT_DATA(dat_data_w[1]),
        .DAT_WE(dat_we_w[1]), .DAT_Q(dat_q_w[1]), .PC_LOAD(pc_load_w[1]), .PC_VAL(pc_val_w[1])
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Data RAM models: 1-cycle and 2-cycle synchronous read latency.
    logic [31:0] mem0 [256];
    logic [31:0] mem1 [256];
    logic [31:0] q1a;
    always @(posedge CLK) begin
        dat_q_w[0] <= mem0[dat_addr_w[0]];
        q1a        <= mem1[dat_addr_w[1]];
        dat_q_w[1] <= q1a;
        if (dat_we_w[0]) mem0[dat_addr_w[0]] = dat_data_w[0];
        if (dat_we_w[1]) mem1[dat_addr_w[1]] = dat_data_w[1];
    end

    int          prg_wr_cnt [2];
    int          dat_wr_cnt [2];
    int          pc_ld_cnt  [2];
    logic [7:0]  last_pa    [2];
    logic [31:0] last_pd    [2];
    logic [7:0]  last_da    [2];
    logic [31:0] last_dd    [2];
    int          both_we;

    always @(negedge CLK) begin
        for (int k = 0; k < 2; k++) begin
            if (prg_we_w[k]) begin
                prg_wr_cnt[k]++;
                last_pa[k] = prg_addr_w[k];
                last_pd[k] = prg_data_w[k];
            end
            if (dat_we_w[k]) begin
                dat_wr_cnt[k]++;
                last_da[k] = dat_addr_w[k];
                last_dd[k] = dat_data_w[k];
            end
            if (pc_load_w[k]) pc_ld_cnt[k]++;
            if (prg_we_w[k] && dat_we_w[k]) both_we++;
        end
    end

    int n_chk;
    int n_pass;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endfunction

    function automatic logic [31:0] init_word(int a);
        return (a == 'h40) ? 32'h1234_5678 : (32'hC0DE_0000 | 32'(a));
    endfunction

    // Reference model state, per instance.
    logic [7:0]  m_prg [2];
    logic [7:0]  m_dat [2];
    logic [7:0]  m_pcv [2];
    logic [31:0] ref_mem [2][256];
    logic [31:0] exp_do_g;
    int          exp_lat_g;

    task automatic access(input int k, input bit we, input logic [1:0] a, input logic [31:0] di,
                          input bit ex, input bit ex_mid,
                          output logic [31:0] do_act, output int lat);
        int pw0, dw0, pl0, extra;
        bit e_pw, e_dw, e_pl, got;
        logic [7:0] e_addr;
        pw0 = prg_wr_cnt[k]; dw0 = dat_wr_cnt[k]; pl0 = pc_ld_cnt[k];
        e_pw = 0; e_dw = 0; e_pl = 0; e_addr = '0;
        exp_lat_g = 2;
        exp_do_g  = 32'h0;
        if (we) begin
            case (a)
                2'd0: begin
                    m_prg[k] = di[7:0];
                    if (di[15]) begin e_pl = 1; m_pcv[k] = di[7:0]; end
                end
                2'd1: if (!ex) begin e_pw = 1; e_addr = m_prg[k]; m_prg[k] = m_prg[k] + 8'd1; end
                2'd2: m_dat[k] = di[7:0];
                default: if (!ex) begin
                    e_dw = 1; e_addr = m_dat[k]; ref_mem[k][m_dat[k]] = di; m_dat[k] = m_dat[k] + 8'd1;
                end
            endcase
        end else begin
            case (a)
                2'd2: exp_do_g = 32'(m_dat[k]);
                2'd3: begin
                    exp_do_g  = ref_mem[k][m_dat[k]];
                    m_dat[k]  = m_dat[k] + 8'd1;
                    exp_lat_g = 2 + k + 1;
                end
                default: exp_do_g = 32'h0;
            endcase
        end

        @(negedge CLK);
        WE = we; A = a; DI = di; DSP_EX = ex; ce[k] = 1'b1;
        lat = 0; got = 0;
        while (!got && lat < 20) begin
            @(negedge CLK);
            lat++;
            if (ex_mid && lat == 1) DSP_EX = 1'b1;
            if (rdy_w[k]) got = 1;
        end
        chk("rdy_seen", 32'(got), 32'd1);
        do_act = do_w[k];
        // Host reacts a cycle late, so CE stays high through the ignore cycle.
        @(negedge CLK);
        chk("rdy_one_cycle", 32'(rdy_w[k]), 32'd0);
        ce[k] = 1'b0;
        extra = 0;
        repeat (3) begin
            @(negedge CLK);
            if (rdy_w[k]) extra++;
        end
        chk("no_reaccept", 32'(extra), 32'd0);
        chk("prg_wr_count", 32'(prg_wr_cnt[k] - pw0), 32'(e_pw));
        if (e_pw) begin
            chk("prg_wr_addr", 32'(last_pa[k]), 32'(e_addr));
            chk("prg_wr_data", last_pd[k], di);
        end
        chk("dat_wr_count", 32'(dat_wr_cnt[k] - dw0), 32'(e_dw));
        if (e_dw) begin
            chk("dat_wr_addr", 32'(last_da[k]), 32'(e_addr));
            chk("dat_wr_data", last_dd[k], di);
        end
        chk("pc_load_cycles", 32'(pc_ld_cnt[k] - pl0), 32'(e_pl));
        chk("pc_val", 32'(pc_val_w[k]), 32'(m_pcv[k]));
    endtask

    typedef struct {
        int          k;
        bit          we;
        logic [1:0]  a;
        logic [31:0] di;
        bit          ex;
        bit          ex_mid;
        bit          chk_do;
        logic [31:0] e_do;
        int          e_lat;
        logic [7:0]  e_prg;
        logic [7:0]  e_dat;
    } vec_t;

    vec_t tbl [17];

    initial begin
        logic [31:0] d;
        int          lat;
        int          rcnt;
        n_chk = 0; n_pass = 0; both_we = 0;
        RST_N = 1'b0; ce[0] = 1'b0; ce[1] = 1'b0;
        WE = 1'b0; A = 2'd0; DI = '0; DSP_EX = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_prg[k] = '0; m_dat[k] = '0; m_pcv[k] = '0;
            prg_wr_cnt[k] = 0; dat_wr_cnt[k] = 0; pc_ld_cnt[k] = 0;
            for (int i = 0; i < 256; i++) ref_mem[k][i] = init_word(i);
        end
        for (int i = 0; i < 256; i++) begin
            mem0[i] = init_word(i);
            mem1[i] = init_word(i);
        end

        tbl[0]  = '{0, 1, 2'd0, 32'h0000_0010, 0, 0, 0, 32'h0,         2, 8'h10, 8'h00};
        tbl[1]  = '{0, 1, 2'd1, 32'h0000_000A, 0, 0, 0, 32'h0,         2, 8'h11, 8'h00};
        tbl[2]  = '{0, 1, 2'd1, 32'h0000_000B, 0, 0, 0, 32'h0,         2, 8'h12, 8'h00};
        tbl[3]  = '{0, 1, 2'd1, 32'h0000_000C, 0, 0, 0, 32'h0,         2, 8'h13, 8'h00};
        tbl[4]  = '{0, 1, 2'd0, 32'h0000_80FF, 0, 0, 0, 32'h0,         2, 8'hFF, 8'h00};
        tbl[5]  = '{0, 1, 2'd1, 32'h0000_0001, 0, 0, 0, 32'h0,         2, 8'h00, 8'h00};
        tbl[6]  = '{0, 1, 2'd1, 32'h0000_0002, 0, 0, 0, 32'h0,         2, 8'h01, 8'h00};
        tbl[7]  = '{0, 1, 2'd2, 32'h0000_003F, 0, 0, 0, 32'h0,         2, 8'h01, 8'h3F};
        tbl[8]  = '{0, 1, 2'd3, 32'h0000_0055, 0, 0, 0, 32'h0,         2, 8'h01, 8'h40};
        tbl[9]  = '{0, 1, 2'd2, 32'h0000_0040, 0, 0, 0, 32'h0,         2, 8'h01, 8'h40};
        tbl[10] = '{0, 0, 2'd3, 32'h0,         0, 0, 1, 32'h1234_5678, 3, 8'h01, 8'h41};
        tbl[11] = '{1, 1, 2'd2, 32'h0000_0040, 0, 0, 0, 32'h0,         2, 8'h00, 8'h40};
        tbl[12] = '{1, 0, 2'd3, 32'h0,         0, 0, 1, 32'h1234_5678, 4, 8'h00, 8'h41};
        tbl[13] = '{0, 1, 2'd1, 32'h0000_DEAD, 1, 0, 0, 32'h0,         2, 8'h01, 8'h41};
        tbl[14] = '{0, 0, 2'd2, 32'h0,         0, 0, 1, 32'h0000_0041, 2, 8'h01, 8'h41};
        tbl[15] = '{0, 0, 2'd1, 32'h0,         0, 0, 1, 32'h0,         2, 8'h01, 8'h41};
        tbl[16] = '{1, 0, 2'd3, 32'h0,         0, 1, 1, 32'hC0DE_0041, 4, 8'h00, 8'h42};

        repeat (3) @(negedge CLK);
        for (int k = 0; k < 2; k++) begin
            chk("reset_do",       do_w[k],              32'h0);
            chk("reset_rdy",      32'(rdy_w[k]),        32'h0);
            chk("reset_prg_addr", 32'(prg_addr_w[k]),   32'h0);
            chk("reset_dat_addr", 32'(dat_addr_w[k]),   32'h0);
            chk("reset_we",       32'({prg_we_w[k], dat_we_w[k]}), 32'h0);
            chk("reset_pc",       32'({pc_load_w[k], pc_val_w[k]}), 32'h0);
        end
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);

        for (int i = 0; i < 17; i++) begin
            access(tbl[i].k, tbl[i].we, tbl[i].a, tbl[i].di, tbl[i].ex, tbl[i].ex_mid, d, lat);
            chk("vec_latency",  32'(lat), 32'(tbl[i].e_lat));
            if (tbl[i].chk_do) chk("vec_do", d, tbl[i].e_do);
            chk("vec_prg_addr", 32'(prg_addr_w[tbl[i].k]), 32'(tbl[i].e_prg));
            chk("vec_dat_addr", 32'(dat_addr_w[tbl[i].k]), 32'(tbl[i].e_dat));
        end

        // Reset while the RD_LAT=2 instance sits in RD_WAIT.
        @(negedge CLK);
        WE = 1'b0; A = 2'd3; DSP_EX = 1'b0; ce[1] = 1'b1;
        @(negedge CLK);
        RST_N = 1'b0; ce[1] = 1'b0;
        rcnt = 0;
        repeat (3) begin
            @(negedge CLK);
            if (rdy_w[0] || rdy_w[1]) rcnt++;
        end
        chk("rst_mid_dat_addr", 32'(dat_addr_w[1]), 32'h0);
        chk("rst_mid_prg_addr", 32'(prg_addr_w[0]), 32'h0);
        chk("rst_mid_pc_val",   32'(pc_val_w[0]),   32'h0);
        RST_N = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            if (rdy_w[0] || rdy_w[1]) rcnt++;
        end
        chk("rst_mid_no_rdy", 32'(rcnt), 32'h0);
        for (int k = 0; k < 2; k++) begin
            m_prg[k] = '0; m_dat[k] = '0; m_pcv[k] = '0;
        end
        access(1, 0, 2'd2, 32'h0, 0, 0, d, lat);
        chk("post_rst_pda_do",  d, 32'h0);
        chk("post_rst_pda_lat", 32'(lat), 32'd2);

        for (int i = 0; i < 80; i++) begin
            int          k;
            bit          we, ex, exm;
            logic [1:0]  a;
            logic [31:0] di;
            k   = int'($urandom_range(0, 1));
            we  = 1'($urandom_range(0, 1));
            a   = 2'($urandom_range(0, 3));
            di  = $urandom;
            ex  = ($urandom_range(0, 3) == 0);
            exm = !we && ($urandom_range(0, 1) == 1);
            access(k, we, a, di, ex, exm, d, lat);
            chk("rnd_latency",  32'(lat), 32'(exp_lat_g));
            if (!we) chk("rnd_do", d, exp_do_g);
            chk("rnd_prg_addr", 32'(prg_addr_w[k]), 32'(m_prg[k]));
            chk("rnd_dat_addr", 32'(dat_addr_w[k]), 32'(m_dat[k]));
        end

        chk("we_exclusive", 32'(both_we), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
